tone_sequencer: RTL and testbench
=================================

Name: tone_sequencer

Overview:
- Parametrised successor to the two-tone siren generator. Steps through NUM_TONES square-wave tones with a programmable dwell time per step and four sequencing modes.
- All timing comes from clk-enable counters on the single clock. No derived clocks and no posedge-of-pulse logic.
- Sits between the alarm/control FSM (on, mode, tone table) and the speaker pin driver.

Parameters:
- NUM_TONES, 4, number of tone slots (>=1).
- DIV_W, 20, width of each half-period entry, in clk cycles.
- DWELL_W, 25, width of the dwell count.
- IDX_W, $clog2(NUM_TONES) (min 1), width of tone_idx.

Ports:
- clk  input  1  system clock, 27 MHz in the lab build.
- reset_n  input  1  asynchronous, active-low reset.
- on  input  1  run enable, level-sensitive.
- mode  input  2  sequencing mode: 0 LOOP, 1 PINGPONG, 2 ONESHOT, 3 HOLD.
- half_period  input  NUM_TONES*DIV_W  flat tone table; slot i is at [i*DIV_W +: DIV_W]. 0 = rest (silent).
- dwell  input  DWELL_W  clk cycles spent on each tone step.
- speaker  output  1  square-wave output, registered.
- tone_idx  output  IDX_W  currently playing slot.
- step_pulse  output  1  one-cycle strobe on each tone advance.
- done  output  1  ONESHOT sequence finished, level.

Behaviour:
- Reset (reset_n=0, async): state IDLE, speaker=0, tone_idx=0, step_pulse=0, done=0, all counters 0, direction=up.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on the first edge where on=1. mode is latched into mode_q at this edge.
  - RUN -> IDLE on any edge where on=0. speaker goes to 0 at that edge; tone_idx and counters are cleared.
  - RUN -> DONE in ONESHOT at the end of the last slot's dwell. speaker=0 and done=1 in DONE.
  - DONE -> IDLE when on=0. done clears at that edge.
- Tone counter, in RUN:
  - hp_cnt increments each cycle.
  - When hp_cnt >= half_period[tone_idx]-1: speaker toggles and hp_cnt resets to 0.
  - The comparison is >=, so shrinking the table mid-count ends the current half-period on the next cycle.
  - half_period=0 forces speaker=0 and holds hp_cnt=0 for the whole step.
  - half_period=1 toggles speaker every cycle.
  - First toggle occurs hp[0] cycles after the RUN entry edge.
- Dwell counter, in RUN:
  - dw_cnt increments each cycle.
  - At dw_cnt == dwell-1: dw_cnt resets to 0, step_pulse=1 for one cycle, tone_idx advances per mode_q, hp_cnt resets to 0, speaker is forced to 0.
  - mode is re-latched into mode_q only at this advance edge. A mid-step mode change has no effect until the next advance.
  - dwell=0: no advance ever (acts as HOLD) and step_pulse stays 0.
- Advance rules:
  - LOOP: idx+1, wrapping NUM_TONES-1 -> 0.
  - PINGPONG: direction flips at 0 and at NUM_TONES-1, so the sequence is 0,1,..,N-1,N-2,..,0,1 with ends not repeated. NUM_TONES=1 stays at 0.
  - ONESHOT: idx+1. The advance out of NUM_TONES-1 goes to DONE instead and tone_idx stays at NUM_TONES-1.
  - HOLD: idx unchanged; step_pulse still fires every dwell.
- Simultaneous events:
  - on=0 has priority over advance and toggle.
  - If an advance and a half-period toggle coincide, the advance wins: speaker=0, hp_cnt=0.
- Table and dwell inputs are sampled live each cycle with no latching. The upstream block holds them stable for deterministic timing.
- Widths: counters are unsigned with no overflow. half_period and dwell values are compared directly.

Decomposition:
- Shared package holds the mode encodings (MODE_LOOP=0, MODE_PINGPONG=1, MODE_ONESHOT=2, MODE_HOLD=3) and the state encodings (IDLE, RUN, DONE).
- One sub-module: tone_divider. It contains the half-period counter and the speaker toggle flop, with inputs clk, reset_n, run, clear, half_period and output square. The top module keeps the FSM, the dwell counter and the index logic.

Test Plan:
- All scenarios use NUM_TONES=4 and DIV_W=8.
- LOOP, table {2,3,4,0}, dwell=12, on=1:
  - speaker period is 4 for cycles 1-12, then period 6 and period 8 on the following steps.
  - tone_idx goes 0->1->2->3->0.
  - step_pulse fires every 12 cycles.
  - speaker stays 0 throughout slot 3.
- PINGPONG, dwell=5: tone_idx sequence is 0,1,2,3,2,1,0,1 with a step_pulse at each change.
- ONESHOT, dwell=5:
  - After 20 cycles, done=1, speaker=0 and tone_idx=3.
  - Dropping on returns to IDLE with done=0 on the next edge.
- on dropped mid-step (cycle 7 of slot 1): on the next edge, speaker=0, tone_idx=0, counters 0. Re-asserting on restarts from slot 0 with the first toggle after hp[0] cycles.
- reset_n pulsed low mid-RUN between clk edges: outputs go to 0 immediately, without waiting for a clk edge.
- mode changed LOOP->HOLD at cycle 3 of a 12-cycle dwell: the next advance still follows LOOP; from then on tone_idx is held.
- dwell=0: tone_idx stays at 0 indefinitely and step_pulse is never asserted.

Source files
------------

// File: rtl/tone_sequencer_pkg.sv
// Shared encodings for the tone sequencer: sequencing modes, FSM states and
// ping-pong direction.
package tone_sequencer_pkg;

    typedef enum logic [1:0] {
        MODE_LOOP     = 2'd0,
        MODE_PINGPONG = 2'd1,
        MODE_ONESHOT  = 2'd2,
        MODE_HOLD     = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/tone_sequencer_divider.sv
// Half-period counter and speaker toggle flop. A half_period of 0 is a rest:
// the output stays low and the counter is parked at 0. clear has priority and
// returns both the counter and the output to 0.
module tone_divider #(
    parameter int DIV_W = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic             clear,
    input  logic [DIV_W-1:0] half_period,
    output logic             square
);

    logic [DIV_W-1:0] hp_cnt;

    // Count clk cycles and toggle the output at the end of each half-period.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hp_cnt <= '0;
            square <= 1'b0;
        end else if (clear) begin
            hp_cnt <= '0;
            square <= 1'b0;
        end else if (run) begin
            if (half_period == '0) begin
                hp_cnt <= '0;
                square <= 1'b0;
            end else if (hp_cnt >= half_period - DIV_W'(1)) begin
                // >= so a table entry shrunk mid-count ends the half-period
                // on the next cycle instead of running to wrap-around.
                hp_cnt <= '0;
                square <= ~square;
            end else begin
                hp_cnt <= hp_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/tone_sequencer.sv
// Multi-tone square-wave sequencer. Steps through NUM_TONES half-period slots,
// spending `dwell` clk cycles on each, in LOOP, PINGPONG, ONESHOT or HOLD
// order. All timing is clk-enable counting on the single clock.
module tone_sequencer
    import tone_sequencer_pkg::*;
#(
    parameter int NUM_TONES = 4,
    parameter int DIV_W     = 20,
    parameter int DWELL_W   = 25,
    parameter int IDX_W     = (NUM_TONES > 1) ? $clog2(NUM_TONES) : 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       on,
    input  logic [1:0]                 mode,
    input  logic [NUM_TONES*DIV_W-1:0] half_period,
    input  logic [DWELL_W-1:0]         dwell,
    output logic                       speaker,
    output logic [IDX_W-1:0]           tone_idx,
    output logic                       step_pulse,
    output logic                       done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TONES - 1);

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    dir_e               dir_q, dir_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DWELL_W-1:0] dw_cnt, dw_d;
    logic               step_q, step_d;
    logic               advance;
    logic [DIV_W-1:0]   hp_sel;
    logic               div_run;
    logic               div_clear;

    // Live table lookup for the slot currently playing.
    assign hp_sel = half_period[int'(idx_q) * DIV_W +: DIV_W];

    // The divider only counts in RUN; leaving RUN, on dropping, or a step
    // advance all restart it from a low output.
    assign div_run   = (state_q == RUN);
    assign div_clear = (state_q != RUN) || !on || advance;

    tone_divider #(
        .DIV_W (DIV_W)
    ) u_divider (
        .clk         (clk),
        .reset_n     (reset_n),
        .run         (div_run),
        .clear       (div_clear),
        .half_period (hp_sel),
        .square      (speaker)
    );

    // Next-state, dwell counting and index sequencing.
    // NOTE: every signal written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        idx_d   = idx_q;
        dw_d    = dw_cnt;
        step_d  = 1'b0;
        advance = 1'b0;

        case (state_q)
            IDLE: begin
                if (on) begin
                    state_d = RUN;
                    mode_d  = mode_e'(mode);
                    dir_d   = DIR_UP;
                    idx_d   = '0;
                    dw_d    = '0;
                end
            end

            RUN: begin
                if (!on) begin
                    // Dropping on beats any coincident advance or toggle.
                    state_d = IDLE;
                    dir_d   = DIR_UP;
                    idx_d   = '0;
                    dw_d    = '0;
                end else if (dwell == '0) begin
                    // A zero dwell never advances; park the counter.
                    dw_d = '0;
                end else if (dw_cnt == dwell - DWELL_W'(1)) begin
                    advance = 1'b1;
                    step_d  = 1'b1;
                    dw_d    = '0;
                    // The advance follows the mode latched at the previous
                    // advance; the new mode takes effect from the next one.
                    mode_d  = mode_e'(mode);
                    case (mode_q)
                        MODE_LOOP: begin
                            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
                        end
                        MODE_PINGPONG: begin
                            if (NUM_TONES == 1) begin
                                idx_d = idx_q;
                            end else if (dir_q == DIR_UP) begin
                                if (idx_q == LAST_IDX) begin
                                    idx_d = idx_q - IDX_W'(1);
                                    dir_d = DIR_DOWN;
                                end else begin
                                    idx_d = idx_q + IDX_W'(1);
                                end
                            end else begin
                                if (idx_q == '0) begin
                                    idx_d = idx_q + IDX_W'(1);
                                    dir_d = DIR_UP;
                                end else begin
                                    idx_d = idx_q - IDX_W'(1);
                                end
                            end
                        end
                        MODE_ONESHOT: begin
                            if (idx_q == LAST_IDX) begin
                                state_d = DONE;
                            end else begin
                                idx_d = idx_q + IDX_W'(1);
                            end
                        end
                        default: begin
                            idx_d = idx_q;
                        end
                    endcase
                end else begin
                    dw_d = dw_cnt + DWELL_W'(1);
                end
            end

            DONE: begin
                if (!on) begin
                    state_d = IDLE;
                    dir_d   = DIR_UP;
                    idx_d   = '0;
                    dw_d    = '0;
                end
            end

            default: begin
                state_d = IDLE;
                dir_d   = DIR_UP;
                idx_d   = '0;
                dw_d    = '0;
            end
        endcase
    end

    // State, mode, direction, index, dwell counter and strobe registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            mode_q  <= MODE_LOOP;
            dir_q   <= DIR_UP;
            idx_q   <= '0;
            dw_cnt  <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            idx_q   <= idx_d;
            dw_cnt  <= dw_d;
            step_q  <= step_d;
        end
    end

    assign tone_idx   = idx_q;
    assign step_pulse = step_q;
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench for tone_sequencer: each scenario queues the tone_idx it
// expects at every step_pulse; a negedge monitor pops and compares on each
// strobe. Directed per-cycle checks cover speaker, index, done and reset.
module tb_tone_sequencer;

    localparam int NUM_TONES = 4;
    localparam int DIV_W     = 8;
    localparam int DWELL_W   = 25;
    localparam int IDX_W     = 2;

    logic                       clk = 1'b0;
    logic                       reset_n;
    logic                       on;
    logic [1:0]                 mode;
    logic [NUM_TONES*DIV_W-1:0] half_period;
    logic [DWELL_W-1:0]         dwell;
    logic                       speaker;
    logic [IDX_W-1:0]           tone_idx;
    logic                       step_pulse;
    logic                       done;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];
    int mon_exp;
    int tbl[4] = '{2, 3, 4, 0};

    tone_sequencer #(
        .NUM_TONES (NUM_TONES),
        .DIV_W     (DIV_W),
        .DWELL_W   (DWELL_W),
        .IDX_W     (IDX_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .on          (on),
        .mode        (mode),
        .half_period (half_period),
        .dwell       (dwell),
        .speaker     (speaker),
        .tone_idx    (tone_idx),
        .step_pulse  (step_pulse),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected speaker k edges into a LOOP run with dwell 12 and table {2,3,4,0}.
    function automatic logic loop_spk(input int k);
        int j;
        int h;
        j = k % 12;
        h = tbl[(k / 12) % 4];
        if (j == 0 || h == 0) return 1'b0;
        return logic'((j / h) % 2);
    endfunction

    // Scoreboard monitor: every step_pulse must match the next queued index,
    // and the advance forces the speaker low.
    always @(negedge clk) begin
        if (step_pulse !== 1'b0) begin
            if (exp_q.size() == 0) begin
                check("step_pulse_unexpected", 32'(step_pulse), 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("step_idx", 32'(tone_idx), 32'(mon_exp));
                check("step_speaker", 32'(speaker), 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        on          = 1'b0;
        mode        = 2'd0;
        half_period = {8'd0, 8'd4, 8'd3, 8'd2};
        dwell       = 25'd12;

        // Reset state.
        tick(2);
        check("rst_speaker", 32'(speaker), 32'd0);
        check("rst_idx", 32'(tone_idx), 32'd0);
        check("rst_step", 32'(step_pulse), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset_n = 1'b1;
        tick(2);
        check("idle_speaker", 32'(speaker), 32'd0);
        check("idle_idx", 32'(tone_idx), 32'd0);

        // LOOP, dwell 12: speaker periods 4/6/8 then rest; index 0,1,2,3,0.
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(0);
        on = 1'b1;
        tick(1);
        check("loop_entry_speaker", 32'(speaker), 32'd0);
        for (int k = 1; k <= 48; k++) begin
            tick(1);
            check("loop_speaker", 32'(speaker), 32'(loop_spk(k)));
            check("loop_idx", 32'(tone_idx), 32'((k / 12) % 4));
        end
        on = 1'b0;
        tick(1);
        check("loop_off_idx", 32'(tone_idx), 32'd0);
        check("loop_pending", 32'(exp_q.size()), 32'd0);

        // on dropped at cycle 7 of slot 1, then restart from slot 0.
        exp_q.push_back(1);
        on = 1'b1;
        tick(1);
        tick(19);
        check("drop_pre_idx", 32'(tone_idx), 32'd1);
        on = 1'b0;
        tick(1);
        check("drop_speaker", 32'(speaker), 32'd0);
        check("drop_idx", 32'(tone_idx), 32'd0);
        check("drop_step", 32'(step_pulse), 32'd0);
        exp_q.push_back(1);
        on = 1'b1;
        tick(1);
        check("restart_e0_speaker", 32'(speaker), 32'd0);
        tick(1);
        check("restart_e1_speaker", 32'(speaker), 32'd0);
        tick(1);
        check("restart_e2_speaker", 32'(speaker), 32'd1);
        tick(9);
        check("restart_e11_idx", 32'(tone_idx), 32'd0);
        tick(1);
        check("restart_e12_idx", 32'(tone_idx), 32'd1);
        on = 1'b0;
        tick(1);
        check("restart_pending", 32'(exp_q.size()), 32'd0);

        // ONESHOT, dwell 5: DONE after 20 cycles holding slot 3.
        mode  = 2'd2;
        dwell = 25'd5;
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(3);
        on = 1'b1;
        tick(1);
        tick(19);
        check("oneshot_e19_done", 32'(done), 32'd0);
        check("oneshot_e19_idx", 32'(tone_idx), 32'd3);
        tick(1);
        check("oneshot_done", 32'(done), 32'd1);
        check("oneshot_speaker", 32'(speaker), 32'd0);
        check("oneshot_idx", 32'(tone_idx), 32'd3);
        tick(3);
        check("oneshot_hold_done", 32'(done), 32'd1);
        check("oneshot_hold_idx", 32'(tone_idx), 32'd3);
        on = 1'b0;
        tick(1);
        check("oneshot_off_done", 32'(done), 32'd0);
        check("oneshot_off_idx", 32'(tone_idx), 32'd0);
        check("oneshot_pending", 32'(exp_q.size()), 32'd0);

        // PINGPONG, dwell 5: 0,1,2,3,2,1,0,1.
        mode = 2'd1;
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(2);
        exp_q.push_back(1);
        exp_q.push_back(0);
        exp_q.push_back(1);
        on = 1'b1;
        tick(1);
        tick(35);
        check("pingpong_end_idx", 32'(tone_idx), 32'd1);
        on = 1'b0;
        tick(1);
        check("pingpong_pending", 32'(exp_q.size()), 32'd0);

        // LOOP -> HOLD at cycle 3: first advance still LOOP, then held.
        mode  = 2'd0;
        dwell = 25'd12;
        exp_q.push_back(1);
        exp_q.push_back(1);
        exp_q.push_back(1);
        on = 1'b1;
        tick(1);
        tick(3);
        mode = 2'd3;
        tick(9);
        check("hold_first_idx", 32'(tone_idx), 32'd1);
        tick(24);
        check("hold_end_idx", 32'(tone_idx), 32'd1);
        on = 1'b0;
        tick(1);
        check("hold_pending", 32'(exp_q.size()), 32'd0);

        // dwell = 0: never advances, tone keeps playing slot 0.
        mode  = 2'd0;
        dwell = 25'd0;
        on    = 1'b1;
        tick(1);
        for (int k = 1; k <= 40; k++) begin
            tick(1);
            check("dwell0_idx", 32'(tone_idx), 32'd0);
            check("dwell0_speaker", 32'(speaker), 32'((k / 2) % 2));
        end
        on = 1'b0;
        tick(1);

        // Asynchronous reset between clk edges mid-RUN.
        dwell = 25'd12;
        exp_q.push_back(1);
        on = 1'b1;
        tick(1);
        tick(15);
        check("areset_pre_speaker", 32'(speaker), 32'd1);
        check("areset_pre_idx", 32'(tone_idx), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("areset_speaker", 32'(speaker), 32'd0);
        check("areset_idx", 32'(tone_idx), 32'd0);
        check("areset_step", 32'(step_pulse), 32'd0);
        check("areset_done", 32'(done), 32'd0);
        on = 1'b0;
        tick(1);
        reset_n = 1'b1;
        tick(1);
        check("areset_post_idx", 32'(tone_idx), 32'd0);
        check("areset_post_speaker", 32'(speaker), 32'd0);
        check("areset_pending", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
